// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier demo controller.
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  localparam logic [1:0] LIGHT_INPUT  = 2'b01;
  localparam logic [1:0] LIGHT_RESULT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    SHOW = 2'd3
  } state_t;

  // Count width for an arbitrary operand width; a 1-bit operand still needs one count bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand latches, accumulator/shift register and adder for the iterative multiply.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic [2*WIDTH-1:0]   src_i,
  output logic [2*WIDTH-1:0]   product_o
);

  logic [WIDTH-1:0]   src1_q;
  logic [WIDTH-1:0]   src2_q;
  logic [2*WIDTH:0]   p_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   p_d;

  // The extra top bit of P holds the adder carry until the shift brings it down.
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, src1_q};
    acc = p_q[0] ? {sum, p_q[WIDTH-1:0]} : p_q;
    p_d = acc >> 1;
  end

  assign product_o = p_d[2*WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src1_q <= '0;
      src2_q <= '0;
      p_q    <= '0;
    end else begin
      if (load_i) begin
        src1_q <= src_i[2*WIDTH-1:WIDTH];
        src2_q <= src_i[WIDTH-1:0];
      end
      if (clear_i) begin
        p_q <= {{(WIDTH+1){1'b0}}, src2_q};
      end else if (step_i) begin
        p_q <= p_d;
      end
    end
  end

endmodule

// File: rtl/mult_controller.sv
// Button-driven sequencer: latches operands, runs the shift-add datapath, holds the product.
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 CLK_in,
  input  logic                 Reset,
  input  logic                 Button_in,
  input  logic [2*WIDTH-1:0]   Switch,
  output logic [2*WIDTH-1:0]   Data_out,
  output logic [1:0]           Light,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  logic               btn_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               done_q;
  logic               press;
  logic [2*WIDTH-1:0] dp_product;

  assign press = Button_in & ~btn_q;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk_i     (CLK_in),
    .rst_i     (Reset),
    .load_i    ((state_q == IDLE) && press),
    .clear_i   (state_q == LOAD),
    .step_i    (state_q == RUN),
    .src_i     (Switch),
    .product_o (dp_product)
  );

  always_ff @(posedge CLK_in) begin
    if (Reset) begin
      state_q   <= IDLE;
      btn_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      btn_q  <= Button_in;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          count_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            product_q <= dp_product;
            state_q   <= SHOW;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        SHOW: begin
          if (press) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outside SHOW the display tracks the switches live.
  assign Data_out = (state_q == SHOW) ? product_q : Switch;
  assign Light    = (state_q == SHOW) ? LIGHT_RESULT : LIGHT_INPUT;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_mult_controller.sv
// Directed bench for mult_controller: reset, multiplies, interference, held button, reset mid-run.
module tb_mult_controller;

  logic        CLK_in;
  logic        Reset;
  logic        Button_in;
  logic [15:0] Switch;
  logic [15:0] Data_out;
  logic [1:0]  Light;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  mult_controller #(.WIDTH(8)) dut (
    .CLK_in    (CLK_in),
    .Reset     (Reset),
    .Button_in (Button_in),
    .Switch    (Switch),
    .Data_out  (Data_out),
    .Light     (Light),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  // One-cycle press; returns at the falling edge following the sampling edge T0.
  task automatic press_once();
    Button_in = 1'b1;
    @(posedge CLK_in);
    @(negedge CLK_in);
    Button_in = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Button_in = 1'b0;
    Switch = 16'h1234;
    repeat (2) @(posedge CLK_in);
    @(negedge CLK_in);
    Reset = 1'b0;
    checks++;
    if (Data_out !== 16'h1234) begin errors++; $display("FAIL reset_data: got %h want 1234", Data_out); end
    checks++;
    if (Light !== 2'b01) begin errors++; $display("FAIL reset_light: got %b want 01", Light); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    @(negedge CLK_in);
    Switch = 16'h5A5A;
    #1;
    checks++;
    if (Data_out !== 16'h5A5A) begin errors++; $display("FAIL idle_passthru: got %h want 5a5a", Data_out); end
  endtask

  task automatic test_basic();
    int busy_cnt;
    Switch = 16'h0C0D;
    @(negedge CLK_in);
    press_once();
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (Busy === 1'b1) busy_cnt++;
      checks++;
      if (Done !== 1'b0) begin errors++; $display("FAIL basic_early_done: cycle %0d got %b want 0", i, Done); end
      @(negedge CLK_in);
    end
    checks++;
    if (busy_cnt != 9) begin errors++; $display("FAIL basic_busy_len: got %0d want 9", busy_cnt); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", Busy); end
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", Done); end
    checks++;
    if (Data_out !== 16'h009C) begin errors++; $display("FAIL basic_product: got %h want 009c", Data_out); end
    checks++;
    if (Light !== 2'b10) begin errors++; $display("FAIL basic_light: got %b want 10", Light); end
    @(negedge CLK_in);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", Done); end
    checks++;
    if (Data_out !== 16'h009C) begin errors++; $display("FAIL basic_hold: got %h want 009c", Data_out); end
    press_once();
    checks++;
    if (Light !== 2'b01) begin errors++; $display("FAIL basic_return_light: got %b want 01", Light); end
    checks++;
    if (Data_out !== 16'h0C0D) begin errors++; $display("FAIL basic_return_data: got %h want 0c0d", Data_out); end
  endtask

  task automatic test_max();
    Switch = 16'hFFFF;
    @(negedge CLK_in);
    press_once();
    repeat (9) @(negedge CLK_in);
    checks++;
    if (Data_out !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h want fe01", Data_out); end
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", Done); end
    @(negedge CLK_in);
    press_once();
  endtask

  task automatic test_zero();
    Switch = 16'h00FF;
    @(negedge CLK_in);
    press_once();
    repeat (9) @(negedge CLK_in);
    checks++;
    if (Data_out !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h want 0000", Data_out); end
    checks++;
    if (Light !== 2'b10) begin errors++; $display("FAIL zero_light: got %b want 10", Light); end
    @(negedge CLK_in);
    press_once();
  endtask

  task automatic test_interference();
    Switch = 16'h0C0D;
    @(negedge CLK_in);
    press_once();
    repeat (2) @(negedge CLK_in);
    Switch = 16'h0202;
    Button_in = 1'b1;
    repeat (3) @(negedge CLK_in);
    Button_in = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL intf_busy_mid: got %b want 1", Busy); end
    repeat (4) @(negedge CLK_in);
    checks++;
    if (Data_out !== 16'h009C) begin errors++; $display("FAIL intf_product: got %h want 009c", Data_out); end
    checks++;
    if (Light !== 2'b10) begin errors++; $display("FAIL intf_light: got %b want 10", Light); end
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL intf_done: got %b want 1", Done); end
    repeat (3) @(negedge CLK_in);
    checks++;
    if (Light !== 2'b10) begin errors++; $display("FAIL intf_no_queued: got %b want 10", Light); end
  endtask

  task automatic test_hold();
    int trans;
    logic [1:0] prev;
    trans = 0;
    prev = Light;
    Button_in = 1'b1;
    repeat (20) begin
      @(negedge CLK_in);
      if (Light !== prev) trans++;
      prev = Light;
    end
    checks++;
    if (trans != 1) begin errors++; $display("FAIL hold_transitions: got %0d want 1", trans); end
    checks++;
    if (Light !== 2'b01) begin errors++; $display("FAIL hold_light: got %b want 01", Light); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", Busy); end
    checks++;
    if (Data_out !== 16'h0202) begin errors++; $display("FAIL hold_data: got %h want 0202", Data_out); end
    Button_in = 1'b0;
    @(negedge CLK_in);
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    Switch = 16'h0C0D;
    @(negedge CLK_in);
    press_once();
    repeat (3) @(negedge CLK_in);
    Reset = 1'b1;
    @(negedge CLK_in);
    Reset = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b want 0", Busy); end
    checks++;
    if (Light !== 2'b01) begin errors++; $display("FAIL rst_run_light: got %b want 01", Light); end
    checks++;
    if (Data_out !== 16'h0C0D) begin errors++; $display("FAIL rst_run_data: got %h want 0c0d", Data_out); end
    done_seen = 0;
    repeat (10) begin
      @(negedge CLK_in);
      if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rst_run_quiet: got %0d active cycles want 0", done_seen); end
    Switch = 16'h0305;
    press_once();
    repeat (8) @(negedge CLK_in);
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL fresh_early: got Done=%b want 0", Done); end
    @(negedge CLK_in);
    checks++;
    if (Data_out !== 16'h000F) begin errors++; $display("FAIL fresh_product: got %h want 000f", Data_out); end
    checks++;
    if (Done !== 1'b1) begin errors++; $display("FAIL fresh_done: got %b want 1", Done); end
  endtask

  initial begin
    Reset = 1'b1;
    Button_in = 1'b0;
    Switch = 16'h0000;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_interference();
    test_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_controller.md
# mult_controller

Sequencing controller for the board-level 8×8 unsigned multiplier demo. It sits between the debounced push-button and switch bank on one side and the seven-segment display driver on the other. On each button press it latches two operands from the switches and runs an iterative shift-add multiplication over a fixed number of cycles. It then holds the product for display until the next press returns the display to live switch values.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.

Ports:
- CLK_in  input  1  system clock; the divided display/logic clock.
- Reset  input  1  synchronous, active-high reset.
- Button_in  input  1  debounced button level; only a rising edge acts.
- Switch  input  2*WIDTH  operands: Src1 = Switch[2*WIDTH-1:WIDTH], Src2 = Switch[WIDTH-1:0].
- Data_out  output  2*WIDTH  value to display: live Switch in IDLE, latched product in SHOW.
- Light  output  2  mode LEDs: 2'b01 when entering operands, 2'b10 when showing the product.
- Busy  output  1  high in LOAD and RUN.
- Done  output  1  one-cycle pulse on the first SHOW cycle.

## Operation
- Edge detect: Btn_q is a register of Button_in, and press = Button_in & ~Btn_q. A held button produces exactly one press.
- FSM states are IDLE, LOAD, RUN and SHOW.
- IDLE: Data_out = Switch (combinational pass-through) and Light = 01. On a press, Src1/Src2 are latched from Switch and the FSM goes to LOAD.
- LOAD (1 cycle): clears the accumulator register P[2*WIDTH:0] and loads P[WIDTH-1:0] = Src2. Count = 0. Next state is RUN.
- RUN (WIDTH cycles): each cycle, if P[0] is set, then P[2*WIDTH:WIDTH] = P[2*WIDTH-1:WIDTH] + Src1, with the carry kept in the extra bit. P then shifts right by 1 and Count increments. When Count == WIDTH-1, the FSM goes to SHOW and Product = P[2*WIDTH-1:0] after the final shift.
- SHOW: Data_out = Product and Light = 10. Done is high only in the first SHOW cycle. On a press, the FSM goes to IDLE.
- Arithmetic is unsigned only, and the result never overflows 2*WIDTH bits.
- Presses in LOAD or RUN are ignored. They are neither queued nor able to abort the operation.
- Switch changes after the latch have no effect on the running operation.
- Reset: state = IDLE; Src1, Src2, P, Count, Product and Btn_q = 0.
  - Resulting outputs: Data_out = Switch, Light = 01, Busy = 0, Done = 0.
  - Reset mid-RUN discards the operation. The first cycle after reset is IDLE.
- Press and Reset in the same cycle: Reset wins and the press is lost.

## Timing
- Btn_q adds no latency to press detection; the press is seen in the cycle Button_in first rises.
- Call the clock edge that samples the press in IDLE T0. At T0, operands are latched and the FSM enters LOAD.
- Busy is high from T0 until T0+1+WIDTH, i.e. T0+9 for WIDTH = 8.
- At T0+1+WIDTH the FSM enters SHOW, and Done and the new Data_out are visible from then on. Total latency is 9 edges for WIDTH = 8.
- Done is exactly one cycle wide.
- Data_out in SHOW is registered. Data_out in IDLE is combinational from Switch.
- Leaving SHOW: at the press-sampling edge the FSM goes to IDLE, and Data_out follows Switch in the next cycle.

## Structure
- Shared package mult_pkg holds:
  - the state enum {IDLE, LOAD, RUN, SHOW};
  - the WIDTH default;
  - the count width $clog2(WIDTH);
  - the light constants LIGHT_INPUT = 2'b01 and LIGHT_RESULT = 2'b10.
- Sub-module mult_datapath holds Src1, the P register, the adder and the shifter. Its controls are load, step and clear, and its output is product.
- mult_controller keeps the FSM, Count, edge detector, output mux and Product register.

## Test plan
- Reset check: assert Reset for 2 cycles with Switch = 0x1234. Expect Data_out = 0x1234, Light = 01, Busy = 0, Done = 0.
- Basic multiply: Switch = 0x0C0D, press once. Expect Busy high for 9 cycles, then Done pulse, Data_out = 0x009C, Light = 10. A second press returns to Data_out = Switch and Light = 01.
- Max operands: Switch = 0xFFFF. Expect Data_out = 0xFE01.
- Zero operand: Switch = 0x00FF. Expect 0x0000.
- Interference during RUN: change Switch to 0x0202 and pulse Button_in during cycles T0+3..T0+5 of a 0x0C0D run. Expect result 0x009C, state SHOW, and no extra press acted on. Then hold Button_in high for 20 cycles and expect exactly one transition.
- Reset mid-RUN: assert Reset at T0+4. Expect IDLE on the next cycle, Busy = 0 and no Done pulse. A fresh press with 0x0305 gives 0x000F.
